// File: rtl/vx_matrix_uop_seq_pkg.sv
// vx_matrix_uop_seq_pkg: macro-op kinds and sequencer state shared by decode and the uop sequencer
package vx_matrix_uop_seq_pkg;

    typedef enum logic [1:0] {
        MOP_NORMAL = 2'd0,
        MOP_MLOAD  = 2'd1,
        MOP_MSTORE = 2'd2,
        MOP_MMUL   = 2'd3
    } mop_kind_t;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_EXPAND = 1'b1
    } seq_state_t;

endpackage

// File: rtl/vx_matrix_uop_seq.sv
// vx_matrix_uop_seq: expands one macro instruction into 1..ROW_MAX register-indexed micro-ops
// on a registered valid/ready output, with back-to-back acceptance and flush.
module vx_matrix_uop_seq
    import vx_matrix_uop_seq_pkg::*;
#(
    parameter int NR_BITS = 6,
    parameter int XLEN    = 32,
    parameter int ROW_MAX = 8,
    parameter int DATAW   = 64,
    localparam int CNT_W  = $clog2(ROW_MAX + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_kind,
    input  logic [CNT_W-1:0]   in_rows,
    input  logic [NR_BITS-1:0] in_rd,
    input  logic [NR_BITS-1:0] in_rs1,
    input  logic [NR_BITS-1:0] in_rs2,
    input  logic [XLEN-1:0]    in_imm,
    input  logic [XLEN-1:0]    in_stride,
    input  logic [DATAW-1:0]   in_payload,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NR_BITS-1:0] out_rd,
    output logic [NR_BITS-1:0] out_rs1,
    output logic [NR_BITS-1:0] out_rs2,
    output logic [XLEN-1:0]    out_imm,
    output logic [CNT_W-1:0]   out_idx,
    output logic               out_acc,
    output logic               out_last,
    output logic [DATAW-1:0]   out_payload,
    output logic               busy
);

    seq_state_t         state_q;
    mop_kind_t          kind_q, kind_d;
    logic [CNT_W-1:0]   k_q, rows_q, rows_d;
    logic [NR_BITS-1:0] rd_q, rs1_q, rs2_q;
    logic [XLEN-1:0]    imm_q, stride_q;
    logic [DATAW-1:0]   payload_q;
    logic               last_q, acc_q, in_fire, out_fire;

    assign kind_d   = mop_kind_t'(in_kind);
    assign rows_d   = (kind_d == MOP_NORMAL || in_rows == '0) ? CNT_W'(1) :
                      (in_rows > CNT_W'(ROW_MAX)) ? CNT_W'(ROW_MAX) : in_rows;
    assign busy     = state_q == S_EXPAND;
    assign in_ready = ~flush && (~busy || (out_ready && last_q));
    assign in_fire  = in_valid && in_ready;
    assign out_fire = busy && out_ready;

    assign out_valid   = busy;
    assign out_rd      = rd_q;
    assign out_rs1     = rs1_q;
    assign out_rs2     = rs2_q;
    assign out_imm     = imm_q;
    assign out_idx     = k_q;
    assign out_acc     = acc_q;
    assign out_last    = last_q;
    assign out_payload = payload_q;

    // Output fields are stepped in place so every micro-op leaves straight from flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            kind_q    <= MOP_NORMAL;
            k_q       <= '0;
            rows_q    <= '0;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            imm_q     <= '0;
            stride_q  <= '0;
            payload_q <= '0;
            last_q    <= 1'b0;
            acc_q     <= 1'b0;
        end else if (flush) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            last_q  <= 1'b0;
            acc_q   <= 1'b0;
        end else if (in_fire) begin
            state_q   <= S_EXPAND;
            kind_q    <= kind_d;
            k_q       <= '0;
            rows_q    <= rows_d;
            rd_q      <= in_rd;
            rs1_q     <= in_rs1;
            rs2_q     <= in_rs2;
            imm_q     <= in_imm;
            stride_q  <= in_stride;
            payload_q <= in_payload;
            last_q    <= rows_d == CNT_W'(1);
            acc_q     <= 1'b0;
        end else if (out_fire) begin
            if (last_q) begin
                state_q <= S_IDLE;
            end else begin
                k_q    <= k_q + CNT_W'(1);
                rd_q   <= rd_q + NR_BITS'(kind_q inside {MOP_MLOAD, MOP_MMUL});
                rs1_q  <= rs1_q + NR_BITS'(kind_q == MOP_MMUL);
                rs2_q  <= rs2_q + NR_BITS'(kind_q == MOP_MSTORE);
                imm_q  <= imm_q + stride_q;
                last_q <= k_q + CNT_W'(2) == rows_q;
                acc_q  <= kind_q == MOP_MMUL;
            end
        end
    end

endmodule
